// File: rtl/ina219_i2c_slave.sv
// INA219 current/power monitor model behind an I2C slave at address 0x40.
// Oversamples scl/sda on clk and drives sda open-drain (0 or z only).
module ina219_i2c_slave (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  localparam logic [6:0]  SLV_ADDR = 7'h40;
  localparam logic [14:0] CFG_RST  = 15'h399F;
  localparam logic [15:0] SHUNT    = 16'h0FA0;
  localparam logic [15:0] BUSV     = 16'h5DC2;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [14:0] cfg_q, cfg_d;
  logic [15:0] cal_q, cal_d;
  logic [7:0]  msb_q, msb_d;
  logic [1:0]  wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_word_q, rd_word_d;
  logic        rd_lsb_q, rd_lsb_d;
  logic        ack_q, ack_d;

  logic scl_now, scl_prev, sda_now, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic signed [32:0] shunt_s, cal_s, cur_prod;
  logic [28:0] pwr_prod;
  logic [15:0] current, power, reg_rdata, wdata;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // [1] is the synchronized level, [2] the previous one for edge detection
  assign scl_now   = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda_now   = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

  assign shunt_s  = {{17{SHUNT[15]}}, SHUNT};
  assign cal_s    = {17'd0, cal_q};
  assign cur_prod = shunt_s * cal_s;
  assign current  = 16'(cur_prod >>> 12);
  assign pwr_prod = {13'd0, current} * {16'd0, BUSV[15:3]};
  assign power    = 16'(pwr_prod >> 12);
  assign wdata    = {msb_q, rx_q};

  always_comb begin
    reg_rdata = 16'h0000;
    case (ptr_q)
      3'd0:    reg_rdata = {1'b0, cfg_q};
      3'd1:    reg_rdata = SHUNT;
      3'd2:    reg_rdata = BUSV;
      3'd3:    reg_rdata = power;
      3'd4:    reg_rdata = current;
      3'd5:    reg_rdata = cal_q;
      default: reg_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[1:0], scl};
    sda_sync_d = {sda_sync_q[1:0], sda};
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    cfg_d      = cfg_q;
    cal_d      = cal_q;
    msb_d      = msb_q;
    wr_cnt_d   = wr_cnt_q;
    rd_word_d  = rd_word_q;
    rd_lsb_d   = rd_lsb_q;
    ack_d      = ack_q;
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_now};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (rx_q[7:1] == SLV_ADDR) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = rx_q[0];
            end else begin
              state_d  = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d   = S_RD_BYTE;
              rd_word_d = reg_rdata;
              tx_d      = reg_rdata[15:8];
              rd_lsb_d  = 1'b1;
              sda_oe_d  = ~reg_rdata[15];
            end else begin
              state_d  = S_WR_BYTE;
              wr_cnt_d = 2'd0;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_now};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = S_WR_ACK;
            sda_oe_d = 1'b1;
            if (wr_cnt_q != 2'd3) wr_cnt_d = wr_cnt_q + 2'd1;
            case (wr_cnt_q)
              2'd0: ptr_d = rx_q[2:0];
              2'd1: msb_d = rx_q;
              2'd2: begin
                if (ptr_q == 3'd0) begin
                  if (wdata[15]) begin
                    cfg_d = CFG_RST;
                    cal_d = 16'h0000;
                  end else begin
                    cfg_d = wdata[14:0];
                  end
                end else if (ptr_q == 3'd5) begin
                  cal_d = {wdata[15:1], 1'b0};
                end
              end
              default: ;
            endcase
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d   = S_WR_BYTE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = S_RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              ack_d     = 1'b0;
            end else if (bit_cnt_q != 4'd0) begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_now;
          end else if (scl_fall) begin
            if (ack_q) begin
              state_d = S_RD_BYTE;
              if (rd_lsb_q) begin
                tx_d     = rd_word_q[7:0];
                sda_oe_d = ~rd_word_q[7];
                rd_lsb_d = 1'b0;
              end else begin
                rd_word_d = reg_rdata;
                tx_d      = reg_rdata[15:8];
                sda_oe_d  = ~reg_rdata[15];
                rd_lsb_d  = 1'b1;
              end
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= 3'd0;
      cfg_q      <= CFG_RST;
      cal_q      <= 16'h0000;
      msb_q      <= 8'h00;
      wr_cnt_q   <= 2'd0;
      rd_word_q  <= 16'h0000;
      rd_lsb_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      ptr_q      <= ptr_d;
      cfg_q      <= cfg_d;
      cal_q      <= cal_d;
      msb_q      <= msb_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_word_q  <= rd_word_d;
      rd_lsb_q   <= rd_lsb_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_ina219_i2c_slave.sv
// Bench for ina219_i2c_slave: a bit-banged I2C master plus a register-level
// model of the INA219 built from plain arithmetic.
module tb_ina219_i2c_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_oe = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ina219_i2c_slave dut (.clk(clk), .rst(rst), .scl(scl), .sda(sda));

  int total = 0;
  int bad   = 0;

  logic [15:0] m_cfg, m_cal;
  logic [2:0]  m_ptr;

  task automatic model_reset();
    m_cfg = 16'h399F;
    m_cal = 16'h0000;
    m_ptr = 3'd0;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] sel);
    longint cur, pwr;
    cur = ((longint'(4000) * longint'(m_cal)) >> 12) & 64'hFFFF;
    pwr = ((cur * 3000) >> 12) & 64'hFFFF;
    case (sel)
      3'd0:    return m_cfg & 16'h7FFF;
      3'd1:    return 16'h0FA0;
      3'd2:    return 16'h5DC2;
      3'd3:    return 16'(pwr);
      3'd4:    return 16'(cur);
      3'd5:    return m_cal;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] sel, input logic [15:0] w);
    if (sel == 3'd0) begin
      if (w[15]) begin
        m_cfg = 16'h399F;
        m_cal = 16'h0000;
      end else begin
        m_cfg = w & 16'h7FFF;
      end
    end else if (sel == 3'd5) begin
      m_cal = w & 16'hFFFE;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One scl period; returns the resolved sda level sampled mid-high.
  task automatic bit_cyc(input logic v, output logic r);
    wait_clk(5);
    m_oe = ~v;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    r = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(5);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    m_oe = 1'b1;
    wait_clk(5);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(5);
    m_oe = 1'b1;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    m_oe = 1'b0;
    wait_clk(5);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cyc(b[i], r);
    bit_cyc(1'b1, r);
    acked = ~r;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] b);
    logic r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cyc(1'b1, r);
      b = {b[6:0], r};
    end
    bit_cyc(~ack, r);
  endtask

  task automatic wr_reg(input logic [7:0] p, input logic [15:0] w, output logic ok);
    logic a0, a1, a2, a3;
    i2c_start();
    wbyte(8'h80, a0);
    wbyte(p, a1);
    wbyte(w[15:8], a2);
    wbyte(w[7:0], a3);
    i2c_stop();
    ok = a0 & a1 & a2 & a3;
    m_ptr = p[2:0];
    model_write(p[2:0], w);
  endtask

  task automatic set_ptr(input logic [7:0] p, output logic ok);
    logic a0, a1;
    i2c_start();
    wbyte(8'h80, a0);
    wbyte(p, a1);
    i2c_stop();
    ok = a0 & a1;
    m_ptr = p[2:0];
  endtask

  // Reads n (1..4) bytes, ACKing all but the last; bytes packed MSB-first.
  task automatic rd_bytes(input int n, output logic [31:0] d, output logic ok);
    logic [7:0] b;
    i2c_start();
    wbyte(8'h81, ok);
    d = 32'h0;
    for (int i = 0; i < n; i++) begin
      rbyte(i != n - 1, b);
      d = {d[23:0], b};
    end
    i2c_stop();
  endtask

  initial begin
    logic ok, a;
    logic [31:0] d;
    logic [7:0] b0, b1;
    logic [7:0] rp, wp;
    logic [15:0] wv;
    logic [6:0] badr;

    model_reset();
    wait_clk(4);
    chk("reset_sda_released", sda, 1'b1);
    rst = 1'b1;
    wait_clk(5);

    // pointer resets to config
    rd_bytes(2, d, ok);
    chk("rd_default_ack", ok, 1'b1);
    chk("rd_default_cfg", d, 32'h399F);

    // shunt through a pointer with upper bits set
    set_ptr(8'h81, ok);
    chk("ptr81_ack", ok, 1'b1);
    rd_bytes(2, d, ok);
    chk("shunt_ack", ok, 1'b1);
    chk("shunt_val", d, 32'h0FA0);

    // wrong address: NACK and nothing written
    i2c_start();
    wbyte(8'h82, a);
    chk("wrong_addr_nack", a, 1'b0);
    wbyte(8'h05, a);
    wbyte(8'h12, a);
    wbyte(8'h34, a);
    i2c_stop();
    set_ptr(8'h00, ok);
    rd_bytes(2, d, ok);
    chk("wrong_addr_cfg", d, 32'h399F);
    set_ptr(8'h05, ok);
    rd_bytes(2, d, ok);
    chk("wrong_addr_cal", d, 32'h0000);

    // calibration and derived registers
    wr_reg(8'h05, 16'h1001, ok);
    chk("cal_wr_ack", ok, 1'b1);
    rd_bytes(2, d, ok);
    chk("cal_val", d, 32'h1000);
    set_ptr(8'h04, ok);
    rd_bytes(2, d, ok);
    chk("current_val", d, 32'h0FA0);
    set_ptr(8'h03, ok);
    rd_bytes(2, d, ok);
    chk("power_val", d, 32'h0B71);

    // config soft reset
    wr_reg(8'h00, 16'h8000, ok);
    chk("cfg_rst_ack", ok, 1'b1);
    rd_bytes(2, d, ok);
    chk("cfg_rst_cfg", d, 32'h399F);
    set_ptr(8'h05, ok);
    rd_bytes(2, d, ok);
    chk("cfg_rst_cal", d, 32'h0000);

    // repeated START between pointer write and read
    i2c_start();
    wbyte(8'h80, a);
    wbyte(8'h02, a);
    i2c_start();
    wbyte(8'h81, a);
    chk("rs_addr_ack", a, 1'b1);
    rbyte(1'b1, b0);
    rbyte(1'b0, b1);
    i2c_stop();
    m_ptr = 3'd2;
    chk("rs_msb", b0, 8'h5D);
    chk("rs_lsb", b1, 8'hC2);

    // reading past the LSB wraps to the same register's MSB
    rd_bytes(4, d, ok);
    chk("wrap_read", d, 32'h5DC25DC2);

    // reset during the LSB byte of a calibration write
    i2c_start();
    wbyte(8'h80, a);
    wbyte(8'h05, a);
    wbyte(8'hAB, a);
    bit_cyc(1'b1, a);
    bit_cyc(1'b1, a);
    bit_cyc(1'b0, a);
    bit_cyc(1'b0, a);
    m_oe = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      wait_clk(1);
      chk("midrst_sda", sda, 1'b1);
    end
    rst = 1'b1;
    wait_clk(5);
    i2c_stop();
    set_ptr(8'h05, ok);
    rd_bytes(2, d, ok);
    chk("midrst_cal", d, 32'h0000);

    // randomized writes and reads against the model
    for (int it = 0; it < 18; it++) begin
      wp = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) wp = {wp[7:3], 3'd5};
      wv = 16'($urandom);
      if (wp[2:0] == 3'd0 && $urandom_range(0, 3) != 0) wv[15] = 1'b0;
      wr_reg(wp, wv, ok);
      chk("rnd_wr_ack", ok, 1'b1);
      rp = 8'($urandom_range(0, 255));
      set_ptr(rp, ok);
      rd_bytes(2, d, ok);
      chk("rnd_rd", d, {16'h0, model_read(rp[2:0])});
      if (it % 6 == 0) begin
        badr = 7'($urandom_range(0, 127));
        if (badr == 7'h40) badr = 7'h41;
        i2c_start();
        wbyte({badr, 1'b0}, a);
        i2c_stop();
        chk("rnd_bad_addr_nack", a, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ina219_i2c_slave.md
# ina219_i2c_slave

Behavioural-synthesizable model of a TI INA219 current/power monitor with an I2C slave port. It answers at 7-bit address 0x40 and decodes I2C transactions from `i2c_master` on the shared open-drain `sda`/`scl` bus. It holds the INA219 register file and computes the current and power registers from fixed measurement values and the calibration register. It serves as the bus target in I2C master verification.

## Interface
- Parameters: none; slave address fixed at 0x40.
- `clk`  in  1  system clock; oversamples the bus.
- `rst`  in  1  reset; synchronous, active-low.
- `scl`  in  1  I2C clock, driven by the master; the slave never stretches it.
- `sda`  inout  1  I2C data, open-drain; the slave drives only 0 or `z`.

## Operation
- Bus sampling: `scl` and `sda` pass through 2-FF synchronizers, then edge-detect on registered copies.
- START: `sda` falls while `scl` is high. STOP: `sda` rises while `scl` is high. Both are accepted in any state.
  - START, including repeated START, goes to ADDR with the bit count cleared.
  - STOP goes to IDLE and releases `sda`.
- Data bits are sampled on `scl` rising edges, MSB first. The slave changes `sda` only after an `scl` falling edge.
- State machine:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits (addr[6:0], R/W). On match with 0x40 → ADDR_ACK. On mismatch → WAIT_STOP, with no ACK (`sda` stays `z`).
  - ADDR_ACK: drive `sda`=0 for the 9th clock. Then go to WR_BYTE if R/W=0, or RD_BYTE if R/W=1.
  - WR_BYTE: shift 8 bits → WR_ACK, which ACKs.
    - 1st byte of a write: loaded into the pointer register (8 bits).
    - 2nd byte: data MSB.
    - 3rd byte: data LSB. The 16-bit word is committed to the addressed register at that ACK.
    - Further bytes are ACKed and ignored.
  - RD_BYTE: drive the MSB of the selected register, then the LSB on the next byte, with `sda` released for 1-bits. The word is latched at the start of the MSB byte.
  - RD_ACK: sample the master's ACK on the 9th clock.
    - ACK → next byte. After the LSB the sequence restarts at the MSB of the same register.
    - NACK → WAIT_STOP.
  - WAIT_STOP: `sda`=`z` until START or STOP.
- Register select is pointer[2:0]; pointer[7:3] is ignored, so 0x81 selects 0x01.
  - 0x00 config: R/W, reset value 0x399F. Writing bit15=1 resets all registers to their reset values; bit15 always reads 0.
  - 0x01 shunt voltage: read-only, constant 0x0FA0.
  - 0x02 bus voltage: read-only, constant 0x5DC2, i.e. value 3000 in bits[15:3] and CNVR=1.
  - 0x03 power: read-only = (current × bus[15:3]) >> 12, unsigned, truncated to 16 bits.
  - 0x04 current: read-only = (signed shunt × calibration) >> 12, truncated to 16 bits.
  - 0x05 calibration: R/W, reset value 0x0000. Bit0 is forced to 0.
  - 0x06–0x07: read 0x0000; writes are ignored.
- Current and power are recomputed combinationally from the current register contents. They read 0 while calibration = 0.

## Timing
- Reset (`rst`=0 at a `clk` edge): state IDLE, `sda`=`z`, pointer=0x00, config=0x399F, calibration=0x0000, bit count 0.
- Reset asserted mid-transaction aborts it at once. No partial register write is committed. The slave re-arms only on a new START.
- Synchronizer latency is 2 `clk` cycles plus 1 for the edge detect.
- `sda` updates within 3 `clk` cycles of the synchronized `scl` falling edge.
  - The bus must keep `scl` low for at least 6 `clk` cycles and high for at least 4 `clk` cycles.
  - The bus must hold `sda` stable for at least 3 `clk` cycles after `scl` falls.
- The ACK drive starts after the falling edge of the 8th `scl` clock. It is released after the falling edge of the 9th.
- A register write takes effect on the `clk` cycle after the 3rd-byte ACK is driven. A read issued after that cycle returns the new value.
- START/STOP detection overrides bit sampling in the same cycle.

## Test plan
- Read shunt: write 0x80 (addr 0x40, W), then pointer 0x81, then STOP. Read with 0x81 and 2 bytes, master ACK then NACK → ACKs on address and pointer; data 0x0F, 0xA0.
- Wrong address: 0x82 (addr 0x41, W) → 9th-clock `sda` high (NACK); no state change; a later read of 0x40 reg 0x00 returns 0x399F.
- Calibration: write reg 0x05 = 0x1001, then read 0x05 → 0x1000. Reading 0x04 → 0x0FA0; reading 0x03 → 0x0B71.
- Config reset: write reg 0x00 = 0x8000, then read 0x00 → 0x399F; reading 0x05 → 0x0000.
- Repeated START: write pointer 0x02, then repeated START with 0x81 and read 2 bytes → 0x5D, 0xC2.
- Reset mid-write: assert `rst`=0 during the LSB byte of a write to 0x05, then read 0x05 → 0x0000; `sda`=`z` throughout reset.
